// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the upstream sender buffer and the UART transmitter.
interface uart_tx_serializer_if;
  logic [7:0] data;
  logic       valid;
  logic       sender_ready;

  modport master (output data, output valid, input sender_ready);
  modport slave  (input data, input valid, output sender_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART byte transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Accepts one byte per sender_ready pulse; back-to-back frames have no idle gap.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  uart_tx_serializer_if.slave    bus,
  output logic                   txd,
  output logic                   busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_d;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic              stop_idx, stop_idx_d;
  logic [7:0]        shift, shift_d;
  logic              par_bit, par_bit_d;
  logic              ready_q, ready_d;
  logic              txd_d, busy_d;

  logic bit_end;
  logic stop_last;
  logic latch;

  assign bus.sender_ready = ready_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      shift    <= '0;
      par_bit  <= '0;
      ready_q  <= '0;
      txd      <= '1;
      busy     <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shift    <= shift_d;
      par_bit  <= par_bit_d;
      ready_q  <= ready_d;
      txd      <= txd_d;
      busy     <= busy_d;
    end
  end

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign stop_last = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
  // ready_q doubles as the guard: upstream is still switching data/valid this cycle.
  assign latch     = ((state == S_IDLE) || stop_last) && bus.valid && !ready_q;

  always_comb begin
    state_d    = state;
    baud_cnt_d = bit_end ? '0 : baud_cnt + 1'b1;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shift_d    = shift;
    par_bit_d  = par_bit;

    unique case (state)
      S_IDLE: begin
        baud_cnt_d = '0;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_idx_d = '0;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_last) state_d = S_IDLE;
          else           stop_idx_d = stop_idx + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      state_d    = S_START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      stop_idx_d = '0;
      shift_d    = bus.data;
      par_bit_d  = (^bus.data) ^ ODD_PARITY;
    end
  end

  // Line level is decoded from the next state so txd is a clean flop output.
  always_comb begin
    ready_d = latch;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover no/even/odd parity and two stop bits.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int TRLEN = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic [3:0] vld;

  always #5 clk = ~clk;

  uart_tx_serializer_if bus0 ();
  uart_tx_serializer_if bus1 ();
  uart_tx_serializer_if bus2 ();
  uart_tx_serializer_if bus3 ();

  assign bus0.data = data;
  assign bus1.data = data;
  assign bus2.data = data;
  assign bus3.data = data;
  assign bus0.valid = vld[0];
  assign bus1.valid = vld[1];
  assign bus2.valid = vld[2];
  assign bus3.valid = vld[3];

  logic txd0, txd1, txd2, txd3;
  logic busy0, busy1, busy2, busy3;
  logic [3:0] txd_v, busy_v, rdy_v;

  assign txd_v  = {txd3, txd2, txd1, txd0};
  assign busy_v = {busy3, busy2, busy1, busy0};
  assign rdy_v  = {bus3.sender_ready, bus2.sender_ready, bus1.sender_ready, bus0.sender_ready};

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .CLK(clk), .reset_n(rst_n), .bus(bus0), .txd(txd0), .busy(busy0));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut1 (
    .CLK(clk), .reset_n(rst_n), .bus(bus1), .txd(txd1), .busy(busy1));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut2 (
    .CLK(clk), .reset_n(rst_n), .bus(bus2), .txd(txd2), .busy(busy2));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) dut3 (
    .CLK(clk), .reset_n(rst_n), .bus(bus3), .txd(txd3), .busy(busy3));

  int n_checks = 0;
  int n_errors = 0;

  logic tr_txd  [TRLEN];
  logic tr_busy [TRLEN];
  logic tr_rdy  [TRLEN];
  logic [7:0] q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream model: presents q[] in order, advancing on each sender_ready pulse.
  // Trace index 0 is the cycle right after the first edge.
  task automatic run(input int sel, input int n);
    int q_idx;
    q_idx     = 0;
    data      = q[0];
    vld[sel]  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tr_txd[i]  = txd_v[sel];
      tr_busy[i] = busy_v[sel];
      tr_rdy[i]  = rdy_v[sel];
      if (rdy_v[sel]) begin
        q_idx++;
        if (q_idx < q.size()) data = q[q_idx];
        else                  vld[sel] = 1'b0;
      end
    end
  endtask

  function automatic int count_rdy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tr_rdy[i]) c++;
    return c;
  endfunction

  function automatic int count_double(input int n);
    int c = 0;
    for (int i = 1; i < n; i++) if (tr_rdy[i] && tr_rdy[i-1]) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tr_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [63:0] txd_vec(input int start, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tr_txd[start + i];
    return v;
  endfunction

  // Frame bits (bit j = j-th serial bit) held CPB cycles each, idle-high up to total.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits, input int total);
    logic [63:0] v = '0;
    for (int i = 0; i < total; i++) v[i] = 1'b1;
    for (int j = 0; j < nbits; j++)
      for (int c = 0; c < CPB; c++) v[j*CPB + c] = bits[j];
    return v;
  endfunction

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b = '0;
    for (int k = 0; k < 8; k++) b[k] = tr_txd[base + CPB*(1 + k) + CPB/2];
    return b;
  endfunction

  logic [7:0] stream_exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    rst_n = 1'b0;
    vld   = '0;
    data  = 8'hA5;
    vld[0] = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_txd", txd_v, 4'hF);
      check("rst_rdy", rdy_v, 4'h0);
      check("rst_busy", busy_v, 4'h0);
    end
    rst_n = 1'b1;

    // 0xA5: {stop, A5, start} = 1_10100101_0
    q = '{8'hA5};
    run(0, 48);
    check("a5_first_latch", tr_rdy[0], 1);
    check("a5_pulses", count_rdy(48), 1);
    check("a5_busy", count_busy(48), 40);
    check("a5_txd", txd_vec(0, 48), expand(16'b1101001010, 10, 48));

    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run(0, 200);
    check("stream_pulses", count_rdy(200), 4);
    check("stream_double", count_double(200), 0);
    check("stream_pulse_pos", {tr_rdy[0], tr_rdy[40], tr_rdy[80], tr_rdy[120]}, 4'hF);
    check("stream_busy", count_busy(200), 160);
    for (int k = 0; k < 4; k++) begin
      check("stream_byte", decode(k*40), stream_exp[k]);
      check("stream_framing", {tr_txd[k*40 + 2], tr_txd[k*40 + 38]}, 2'b01);
    end
    check("stream_tail", txd_vec(160, 40), 64'hFF_FFFF_FFFF);

    // even parity, 0x07: {stop, par=1, 07, start}
    q = '{8'h07};
    run(1, 52);
    check("even_pulses", count_rdy(52), 1);
    check("even_busy", count_busy(52), 44);
    check("even_txd", txd_vec(0, 52), expand(16'b11000001110, 11, 52));

    // odd parity, 0x07: parity bit 0
    q = '{8'h07};
    run(2, 52);
    check("odd_busy", count_busy(52), 44);
    check("odd_txd", txd_vec(0, 52), expand(16'b10000001110, 11, 52));

    // two stop bits: 0x00 then 0x55 starting on cycle 45
    q = '{8'h00, 8'h55};
    run(3, 96);
    check("stop2_txd", txd_vec(0, 44), expand(16'b11000000000, 11, 44));
    check("stop2_second_pulse", tr_rdy[44], 1);
    check("stop2_pulses", count_rdy(96), 2);
    check("stop2_byte2", decode(44), 8'h55);
    check("stop2_busy", count_busy(96), 88);
    check("stop2_tail", txd_vec(88, 8), 64'hFF);

    // reset during DATA bit 3 of 0x81 (that bit is 0 on the line)
    data   = 8'h81;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    check("mid_pulse", rdy_v[0], 1);
    vld[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("mid_txd_before", txd_v[0], 0);
    rst_n = 1'b0;
    #1;
    check("mid_txd_reset", txd_v[0], 1);
    check("mid_busy_reset", busy_v[0], 0);
    data   = 8'h3C;
    vld[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("mid_rdy_in_reset", rdy_v[0], 0);
    end
    rst_n = 1'b1;
    q = '{8'h3C};
    run(0, 48);
    check("mid_first_latch", tr_rdy[0], 1);
    check("mid_pulses", count_rdy(48), 1);
    check("mid_busy", count_busy(48), 40);
    check("mid_txd", txd_vec(0, 48), expand(16'b1001111000, 10, 48));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-level UART transmitter that sits directly downstream of the 32-bit-to-byte sender buffer on the host-output path. It accepts one byte at a time over a valid/acknowledge handshake and serializes it onto the TX pin as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It returns a one-cycle `sender_ready` pulse per byte accepted, which advances the upstream buffer to its next byte.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `CLK`  input  1  system clock; all logic is on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `data`  input  8  byte to transmit; must be stable while `valid` is high until acknowledged.
- `valid`  input  1  level signal: `data` holds a byte to send.
- `sender_ready`  output  1  registered one-cycle pulse: the byte on `data` has been latched and upstream may present the next byte.
- `txd`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is in progress (START through the last STOP).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - baud counter, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1;
  - bit index, 0..7, for DATA;
  - stop index, 0..STOP_BITS-1.
- Latch condition: (state == IDLE, or final cycle of the last stop bit) AND `valid` AND guard clear.
- On latch, at that clock edge:
  - shift register ← `data`;
  - parity accumulator ← XOR of `data`, inverted for odd parity;
  - `sender_ready` ← 1;
  - `txd` ← 0; state ← START; baud counter ← 0; `busy` ← 1.
- START: `txd` = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `txd` = shift[0]; at the end of each bit, shift right and increment the bit index. After bit 7, go to PARITY if `PARITY` != 0, else STOP.
- PARITY: `txd` = parity bit for one bit period, then STOP.
- STOP: `txd` = 1 for STOP_BITS × CLKS_PER_BIT cycles. In the final cycle, either latch the next byte (if the latch condition holds) or go to IDLE with `busy` ← 0.
- Guard: in the cycle after a `sender_ready` pulse, `valid` is ignored, because upstream changes `data`/`valid` on the edge where it sees the pulse. With CLKS_PER_BIT ≥ 2 the guard never blocks in practice, but it is implemented explicitly.
- Each accepted byte produces exactly one `sender_ready` pulse. No byte is sent twice, even when `valid` stays high across the pulse.
- `valid` deasserting mid-frame has no effect on the current frame.

## Timing
- Reset values, applied asynchronously when `reset_n` = 0: `txd` = 1, `sender_ready` = 0, `busy` = 0, state IDLE, all counters 0.
- Reset mid-frame: `txd` returns to 1 immediately and the byte is dropped, with no further pulse. After release, the block sits in IDLE and latches again on the first cycle in which `valid` is high.
- Latency from `valid` rising in IDLE to the falling edge of `txd`: 1 clock, with `sender_ready` high in that same cycle.
- Frame length: exactly (1 + 8 + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back bytes have no idle gap: the next start bit begins on the cycle after the last stop-bit cycle.
- `sender_ready` is never high for two consecutive cycles.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles with `valid` = 1 → `txd` = 1, `sender_ready` = 0, `busy` = 0 throughout. After release, the first latch happens on the next edge.
- Single byte, with CLKS_PER_BIT = 4, PARITY = 0, STOP_BITS = 1: send 0xA5 → one `sender_ready` pulse; `txd` bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `busy` is high for exactly 40 cycles.
- Word stream: upstream model presents bytes DE, AD, BE, EF, each advancing on `sender_ready`, with `valid` high throughout then dropped after the 4th pulse → exactly 4 pulses; 4 contiguous 40-cycle frames decode to DE AD BE EF; no fifth frame.
- Parity: PARITY = 2, send 0x07 → parity bit 1 and a 44-cycle frame. PARITY = 1, send 0x07 → parity bit 0.
- Two stop bits: STOP_BITS = 2, send 0x00 → stop high for 8 cycles, 44-cycle frame; a second byte starts on cycle 45.
- Reset mid-frame: assert `reset_n` = 0 during DATA bit 3 → `txd` = 1 in the same cycle, `busy` = 0. Release with `valid` high and 0x3C → a full fresh frame with a single `sender_ready` pulse.
